csr_trap_unit: RTL and testbench

Parametrised machine-mode CSR file and trap controller for the pipelined RV32I core; successor to the exception-only CSR unit. Sits beside the XB stage. Takes CSR operations and FD-originated exceptions as before, and adds interrupt support: mstatus/mie/mip, a configurable number of platform-local interrupt lines, mret handling, read-only-CSR write protection, and configurable counter width. Produces the trap/return redirect for the PC logic.

---
 rtl/csr_trap_unit.sv | 216 +++++++++++++++++++++
 tb/tb_csr_trap_unit.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file, interrupt synchronisers and trap/mret redirect beside XB.
// Define CSR_VECTORED_EN to make mtvec[1:0] a writable mode field with vectored interrupts.
module csr_trap_unit #(
    parameter int          NUM_IRQ     = 4,
    parameter int          CNT_WIDTH   = 64,
    parameter logic [31:0] MTVEC_RESET = 32'h4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               xb_bubble,
    input  logic               read,
    input  logic               write,
    input  logic               set,
    input  logic               clear,
    input  logic               imm,
    input  logic [4:0]         a_rd,
    input  logic [11:0]        src_dst,
    input  logic [31:0]        d_rs1,
    input  logic [4:0]         uimm,
    input  logic [31:0]        xb_pc,
    input  logic               exc_valid,
    input  logic [3:0]         exc_cause,
    input  logic [31:0]        exc_tval,
    input  logic               mret,
    input  logic               irq_ext,
    input  logic               irq_timer,
    input  logic               irq_soft,
    input  logic [NUM_IRQ-1:0] irq_local,
    output logic [31:0]        data_out,
    output logic               initiate_trap,
    output logic [31:0]        trap_target,
    output logic               initiate_mret,
    output logic [31:0]        csr_mepc
);
    localparam logic [31:0] LOCAL_MASK = ((32'h1 << NUM_IRQ) - 32'h1) << 16;
    localparam logic [31:0] MIE_MASK   = LOCAL_MASK | 32'h0000_0888;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [2:0]           irq_s1_q, irq_s2_q;
    logic [NUM_IRQ-1:0]   local_s1_q, local_s2_q;
    logic                 status_mie_q, status_mpie_q;
    logic [31:0]          mie_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [29:0]          mtvec_base_q;
    logic [1:0]           mtvec_mode;
    logic [CNT_WIDTH-1:0] mcycle_q, minstret_q, mcycle_next, minstret_next;
    logic                 illegal_q;

    logic [31:0] operand, rdata, wdata, mip_val, mstatus_val, mtvec_val, pend;
    logic [31:0] trap_cause, trap_tval;
    logic [63:0] cyc64, ins64;
    logic        rd_en, mod_en, any_op, implemented, hw_zero, illegal;
    logic        take_irq, retire;
    logic [4:0]  irq_code;

`ifdef CSR_VECTORED_EN
    logic [1:0] mtvec_mode_q;
    assign mtvec_mode = mtvec_mode_q;
`else
    assign mtvec_mode = 2'b00;
`endif

    assign operand = imm ? {27'b0, uimm} : d_rs1;
    assign rd_en   = read & (a_rd != 5'd0) & ~xb_bubble;
    assign mod_en  = ((write & ~(imm & (uimm == 5'd0))) | ((set | clear) & (uimm != 5'd0))) & ~xb_bubble;
    assign any_op  = (read | write | set | clear) & ~xb_bubble;

    assign mstatus_val = {19'b0, 2'b11, 3'b0, status_mpie_q, 3'b0, status_mie_q, 3'b0};
    assign mtvec_val   = {mtvec_base_q, mtvec_mode};
    assign cyc64       = 64'(mcycle_q);
    assign ins64       = 64'(minstret_q);
    assign hw_zero     = (src_dst >= 12'hB03 && src_dst <= 12'hB1F) ||
                         (src_dst >= 12'hB83 && src_dst <= 12'hB9F) ||
                         (src_dst >= 12'h323 && src_dst <= 12'h33F);

    always_comb begin
        mip_val = 32'h0;
        mip_val[3]  = irq_s2_q[0];
        mip_val[7]  = irq_s2_q[1];
        mip_val[11] = irq_s2_q[2];
        mip_val[16 +: NUM_IRQ] = local_s2_q;
    end

    always_comb begin
        implemented = 1'b1;
        rdata = 32'h0;
        case (src_dst)
            12'hF11, 12'hF12, 12'hF13, 12'hF14: rdata = 32'h0;
            12'h301: rdata = 32'h4000_0100;
            12'h300: rdata = mstatus_val;
            12'h304: rdata = mie_q;
            12'h344: rdata = mip_val;
            12'h305: rdata = mtvec_val;
            12'h340: rdata = mscratch_q;
            12'h341: rdata = mepc_q;
            12'h342: rdata = mcause_q;
            12'h343: rdata = mtval_q;
            12'hB00: rdata = cyc64[31:0];
            12'hB80: rdata = cyc64[63:32];
            12'hB02: rdata = ins64[31:0];
            12'hB82: rdata = ins64[63:32];
            default: implemented = hw_zero;
        endcase
    end

    assign wdata   = write ? operand : (set ? (rdata | operand) : (rdata & ~operand));
    assign illegal = (any_op & ~implemented) | (mod_en & (src_dst[11:10] == 2'b11));

    // Fixed interrupt priority: external, software, timer, then lowest local line.
    always_comb begin
        pend = mip_val & mie_q;
        irq_code = 5'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[16 + i]) irq_code = 5'(16 + i);
        end
        if (pend[7])  irq_code = 5'd7;
        if (pend[3])  irq_code = 5'd3;
        if (pend[11]) irq_code = 5'd11;
    end

    assign take_irq      = status_mie_q & (|pend) & ~xb_bubble;
    assign initiate_trap = illegal_q | exc_valid | take_irq;
    assign initiate_mret = mret & ~xb_bubble & ~initiate_trap;
    assign retire        = ~xb_bubble & ~initiate_trap;
    assign csr_mepc      = mepc_q;
    assign trap_cause    = illegal_q ? 32'd2 :
                           exc_valid ? {28'b0, exc_cause} : {1'b1, 26'b0, irq_code};
    assign trap_tval     = (~illegal_q & exc_valid) ? exc_tval : 32'h0;

    always_comb begin
        trap_target = {mtvec_base_q, 2'b00};
`ifdef CSR_VECTORED_EN
        if (mtvec_mode_q == 2'b01 && !illegal_q && !exc_valid)
            trap_target = {mtvec_base_q, 2'b00} + {25'b0, irq_code, 2'b00};
`endif
    end

    // A CSR write to a counter half replaces it and holds off that cycle's increment.
    always_comb begin
        mcycle_next   = mcycle_q + CNT_ONE;
        minstret_next = retire ? (minstret_q + CNT_ONE) : minstret_q;
        if (mod_en) begin
            case (src_dst)
                12'hB00: mcycle_next   = CNT_WIDTH'({cyc64[63:32], wdata});
                12'hB80: mcycle_next   = CNT_WIDTH'({wdata, cyc64[31:0]});
                12'hB02: minstret_next = CNT_WIDTH'({ins64[63:32], wdata});
                12'hB82: minstret_next = CNT_WIDTH'({wdata, ins64[31:0]});
                default: ;
            endcase
        end
    end

    // Trap entry is applied last so it overrides same-cycle CSR writes and mret.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_s1_q      <= 3'b0;
            irq_s2_q      <= 3'b0;
            local_s1_q    <= '0;
            local_s2_q    <= '0;
            status_mie_q  <= 1'b0;
            status_mpie_q <= 1'b0;
            mie_q         <= 32'h0;
            mscratch_q    <= 32'h0;
            mepc_q        <= 32'h0;
            mcause_q      <= 32'h0;
            mtval_q       <= 32'h0;
            mtvec_base_q  <= MTVEC_RESET[31:2];
`ifdef CSR_VECTORED_EN
            mtvec_mode_q  <= (MTVEC_RESET[1:0] == 2'b01) ? 2'b01 : 2'b00;
`endif
            mcycle_q      <= '0;
            minstret_q    <= '0;
            illegal_q     <= 1'b0;
            data_out      <= 32'h0;
        end else begin
            irq_s1_q   <= {irq_ext, irq_timer, irq_soft};
            irq_s2_q   <= irq_s1_q;
            local_s1_q <= irq_local;
            local_s2_q <= local_s1_q;
            illegal_q  <= illegal;
            mcycle_q   <= mcycle_next;
            minstret_q <= minstret_next;
            if (rd_en) data_out <= rdata;
            if (mod_en) begin
                case (src_dst)
                    12'h300: begin
                        status_mie_q  <= wdata[3];
                        status_mpie_q <= wdata[7];
                    end
                    12'h304: mie_q <= wdata & MIE_MASK;
                    12'h305: begin
                        mtvec_base_q <= wdata[31:2];
`ifdef CSR_VECTORED_EN
                        mtvec_mode_q <= (wdata[1:0] == 2'b01) ? 2'b01 : 2'b00;
`endif
                    end
                    12'h340: mscratch_q <= wdata;
                    12'h341: mepc_q     <= wdata & 32'hFFFF_FFFC;
                    12'h342: mcause_q   <= wdata;
                    12'h343: mtval_q    <= wdata;
                    default: ;
                endcase
            end
            if (initiate_mret) begin
                status_mie_q  <= status_mpie_q;
                status_mpie_q <= 1'b1;
            end
            if (initiate_trap) begin
                mepc_q        <= xb_pc & 32'hFFFF_FFFC;
                mcause_q      <= trap_cause;
                mtval_q       <= trap_tval;
                status_mpie_q <= status_mie_q;
                status_mie_q  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed self-checking bench for csr_trap_unit (NUM_IRQ=4, CNT_WIDTH=40).
module tb_csr_trap_unit;
    localparam int NUM_IRQ   = 4;
    localparam int CNT_WIDTH = 40;
`ifdef CSR_VECTORED_EN
    localparam logic [31:0] LOCAL_TARGET = 32'h0000_0148;
    localparam logic [31:0] MTVEC_READ   = 32'h0000_0101;
`else
    localparam logic [31:0] LOCAL_TARGET = 32'h0000_0100;
    localparam logic [31:0] MTVEC_READ   = 32'h0000_0100;
`endif

    logic clk = 1'b0;
    logic reset, xb_bubble, read, write, set, clear, imm;
    logic [4:0] a_rd, uimm;
    logic [11:0] src_dst;
    logic [31:0] d_rs1, xb_pc, exc_tval;
    logic exc_valid, mret, irq_ext, irq_timer, irq_soft;
    logic [3:0] exc_cause;
    logic [NUM_IRQ-1:0] irq_local;
    logic [31:0] data_out, trap_target, csr_mepc;
    logic initiate_trap, initiate_mret;

    int num_checks = 0;
    int num_fail = 0;
    logic [31:0] val;

    csr_trap_unit #(.NUM_IRQ(NUM_IRQ), .CNT_WIDTH(CNT_WIDTH), .MTVEC_RESET(32'h4)) dut (
        .clk(clk), .reset(reset), .xb_bubble(xb_bubble),
        .read(read), .write(write), .set(set), .clear(clear), .imm(imm),
        .a_rd(a_rd), .src_dst(src_dst), .d_rs1(d_rs1), .uimm(uimm), .xb_pc(xb_pc),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval), .mret(mret),
        .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft), .irq_local(irq_local),
        .data_out(data_out), .initiate_trap(initiate_trap), .trap_target(trap_target),
        .initiate_mret(initiate_mret), .csr_mepc(csr_mepc)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        xb_bubble = 1'b1; read = 1'b0; write = 1'b0; set = 1'b0; clear = 1'b0; imm = 1'b0;
        a_rd = 5'd0; uimm = 5'd0; src_dst = 12'h0; d_rs1 = 32'h0;
        exc_valid = 1'b0; exc_cause = 4'd0; exc_tval = 32'h0; mret = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic r, input logic w, input logic s, input logic c,
                            input logic im, input logic [4:0] rd, input logic [11:0] addr,
                            input logic [31:0] rs1, input logic [4:0] u);
        idle_inputs();
        xb_bubble = 1'b0; read = r; write = w; set = s; clear = c; imm = im;
        a_rd = rd; src_dst = addr; d_rs1 = rs1; uimm = u;
    endtask

    task automatic read_csr(input logic [11:0] addr, output logic [31:0] rv);
        drive_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, addr, 32'h0, 5'd0);
        cycle();
        idle_inputs();
        rv = data_out;
    endtask

    task automatic write_csr(input logic [11:0] addr, input logic [31:0] wv);
        drive_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, addr, wv, 5'd1);
        cycle();
        idle_inputs();
    endtask

    task automatic test_reset();
        reset = 1'b1; xb_pc = 32'h0; irq_ext = 1'b0; irq_timer = 1'b0; irq_soft = 1'b0;
        irq_local = '0;
        idle_inputs();
        cycle(); cycle();
        num_checks++;
        if (data_out !== 32'h0) begin num_fail++; $display("[TB] FAIL reset_data_out: got %h want %h", data_out, 32'h0); end
        num_checks++;
        if (initiate_trap !== 1'b0) begin num_fail++; $display("[TB] FAIL reset_trap: got %b want 0", initiate_trap); end
        num_checks++;
        if (csr_mepc !== 32'h0) begin num_fail++; $display("[TB] FAIL reset_mepc: got %h want 0", csr_mepc); end
        reset = 1'b0;
        cycle();
        // csrrs x5, misa, x0
        drive_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 12'h301, 32'h0, 5'd0);
        cycle();
        idle_inputs();
        num_checks++;
        if (data_out !== 32'h4000_0100) begin num_fail++; $display("[TB] FAIL misa_read: got %h want %h", data_out, 32'h4000_0100); end
        num_checks++;
        if (initiate_trap !== 1'b0) begin num_fail++; $display("[TB] FAIL misa_no_trap: got %b want 0", initiate_trap); end
        read_csr(12'h305, val);
        num_checks++;
        if (val !== 32'h4) begin num_fail++; $display("[TB] FAIL mtvec_reset: got %h want %h", val, 32'h4); end
        read_csr(12'h300, val);
        num_checks++;
        if (val !== 32'h1800) begin num_fail++; $display("[TB] FAIL mstatus_reset: got %h want %h", val, 32'h1800); end
    endtask

    task automatic test_illegal();
        // csrrw x1, 0x7C0, x2
        drive_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 12'h7C0, 32'h55, 5'd2);
        xb_pc = 32'h200;
        #1;
        num_checks++;
        if (initiate_trap !== 1'b0) begin num_fail++; $display("[TB] FAIL illegal_same_cycle: got %b want 0", initiate_trap); end
        cycle();
        idle_inputs();
        xb_bubble = 1'b0; xb_pc = 32'h204;
        #1;
        num_checks++;
        if (initiate_trap !== 1'b1) begin num_fail++; $display("[TB] FAIL illegal_trap: got %b want 1", initiate_trap); end
        num_checks++;
        if (trap_target !== 32'h4) begin num_fail++; $display("[TB] FAIL illegal_target: got %h want %h", trap_target, 32'h4); end
        cycle();
        idle_inputs();
        num_checks++;
        if (csr_mepc !== 32'h204) begin num_fail++; $display("[TB] FAIL illegal_mepc: got %h want %h", csr_mepc, 32'h204); end
        read_csr(12'h342, val);
        num_checks++;
        if (val !== 32'h2) begin num_fail++; $display("[TB] FAIL illegal_mcause: got %h want %h", val, 32'h2); end
        read_csr(12'h343, val);
        num_checks++;
        if (val !== 32'h0) begin num_fail++; $display("[TB] FAIL illegal_mtval: got %h want 0", val); end
        // csrrw x1, mhartid, x2 writes a read-only address
        drive_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 12'hF14, 32'h9, 5'd2);
        xb_pc = 32'h300;
        cycle();
        idle_inputs();
        xb_bubble = 1'b0; xb_pc = 32'h304;
        #1;
        num_checks++;
        if (initiate_trap !== 1'b1) begin num_fail++; $display("[TB] FAIL mhartid_trap: got %b want 1", initiate_trap); end
        cycle();
        idle_inputs();
        num_checks++;
        if (csr_mepc !== 32'h304) begin num_fail++; $display("[TB] FAIL mhartid_mepc: got %h want %h", csr_mepc, 32'h304); end
        // csrrs x5, mhartid, x0 only reads, so it is legal
        drive_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 12'hF14, 32'h0, 5'd0);
        cycle();
        idle_inputs();
        num_checks++;
        if (initiate_trap !== 1'b0) begin num_fail++; $display("[TB] FAIL mhartid_read_legal: got %b want 0", initiate_trap); end
    endtask

    task automatic test_irq();
        write_csr(12'h305, 32'h100);
        write_csr(12'h304, 32'h800);
        drive_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 12'h300, 32'h0, 5'd8);
        cycle();
        idle_inputs();
        xb_bubble = 1'b0; xb_pc = 32'h400; irq_ext = 1'b1;
        cycle();
        num_checks++;
        if (initiate_trap !== 1'b0) begin num_fail++; $display("[TB] FAIL irq_sync_delay: got %b want 0", initiate_trap); end
        cycle();
        mret = 1'b1;
        #1;
        num_checks++;
        if (initiate_trap !== 1'b1) begin num_fail++; $display("[TB] FAIL irq_ext_trap: got %b want 1", initiate_trap); end
        num_checks++;
        if (trap_target !== 32'h100) begin num_fail++; $display("[TB] FAIL irq_ext_target: got %h want %h", trap_target, 32'h100); end
        num_checks++;
        if (initiate_mret !== 1'b0) begin num_fail++; $display("[TB] FAIL trap_beats_mret: got %b want 0", initiate_mret); end
        cycle();
        idle_inputs();
        num_checks++;
        if (csr_mepc !== 32'h400) begin num_fail++; $display("[TB] FAIL irq_mepc: got %h want %h", csr_mepc, 32'h400); end
        read_csr(12'h342, val);
        num_checks++;
        if (val !== 32'h8000_000B) begin num_fail++; $display("[TB] FAIL irq_mcause: got %h want %h", val, 32'h8000_000B); end
        read_csr(12'h300, val);
        num_checks++;
        if (val !== 32'h1880) begin num_fail++; $display("[TB] FAIL irq_mstatus: got %h want %h", val, 32'h1880); end
        read_csr(12'h344, val);
        num_checks++;
        if (val !== 32'h800) begin num_fail++; $display("[TB] FAIL mip_ext_set: got %h want %h", val, 32'h800); end
        irq_ext = 1'b0;
        cycle(); cycle(); cycle();
        read_csr(12'h344, val);
        num_checks++;
        if (val !== 32'h0) begin num_fail++; $display("[TB] FAIL mip_ext_clear: got %h want 0", val); end
        idle_inputs();
        xb_bubble = 1'b0; mret = 1'b1;
        #1;
        num_checks++;
        if (initiate_mret !== 1'b1) begin num_fail++; $display("[TB] FAIL mret_redirect: got %b want 1", initiate_mret); end
        cycle();
        idle_inputs();
        read_csr(12'h300, val);
        num_checks++;
        if (val !== 32'h1888) begin num_fail++; $display("[TB] FAIL mret_mstatus: got %h want %h", val, 32'h1888); end
    endtask

    task automatic test_exc_priority();
        irq_ext = 1'b1;
        cycle(); cycle();
        num_checks++;
        if (initiate_trap !== 1'b0) begin num_fail++; $display("[TB] FAIL bubble_blocks_irq: got %b want 0", initiate_trap); end
        xb_bubble = 1'b0; exc_valid = 1'b1; exc_cause = 4'd4; exc_tval = 32'h1003; xb_pc = 32'h500;
        #1;
        num_checks++;
        if (initiate_trap !== 1'b1) begin num_fail++; $display("[TB] FAIL exc_trap: got %b want 1", initiate_trap); end
        cycle();
        idle_inputs();
        read_csr(12'h342, val);
        num_checks++;
        if (val !== 32'h4) begin num_fail++; $display("[TB] FAIL exc_mcause: got %h want %h", val, 32'h4); end
        read_csr(12'h343, val);
        num_checks++;
        if (val !== 32'h1003) begin num_fail++; $display("[TB] FAIL exc_mtval: got %h want %h", val, 32'h1003); end
        num_checks++;
        if (csr_mepc !== 32'h500) begin num_fail++; $display("[TB] FAIL exc_mepc: got %h want %h", csr_mepc, 32'h500); end
        irq_ext = 1'b0;
        cycle(); cycle(); cycle();
    endtask

    task automatic test_back_to_back();
        drive_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 12'h7C0, 32'h1, 5'd1);
        xb_pc = 32'h600;
        cycle();
        idle_inputs();
        xb_bubble = 1'b0; exc_valid = 1'b1; exc_cause = 4'd4; exc_tval = 32'h77; xb_pc = 32'h604;
        cycle();
        idle_inputs();
        read_csr(12'h342, val);
        num_checks++;
        if (val !== 32'h2) begin num_fail++; $display("[TB] FAIL illegal_beats_exc_cause: got %h want %h", val, 32'h2); end
        read_csr(12'h343, val);
        num_checks++;
        if (val !== 32'h0) begin num_fail++; $display("[TB] FAIL illegal_beats_exc_tval: got %h want 0", val); end
        num_checks++;
        if (csr_mepc !== 32'h604) begin num_fail++; $display("[TB] FAIL illegal_beats_exc_mepc: got %h want %h", csr_mepc, 32'h604); end
    endtask

    task automatic test_counters();
        write_csr(12'hB80, 32'hFFFF_FFFF);
        read_csr(12'hB80, val);
        num_checks++;
        if (val !== 32'hFF) begin num_fail++; $display("[TB] FAIL mcycleh_width: got %h want %h", val, 32'hFF); end
        write_csr(12'hB80, 32'h0);
        write_csr(12'hB00, 32'hFFFF_FFFF);
        cycle();
        read_csr(12'hB80, val);
        num_checks++;
        if (val !== 32'h1) begin num_fail++; $display("[TB] FAIL mcycle_carry: got %h want %h", val, 32'h1); end
        read_csr(12'hB00, val);
        num_checks++;
        if (val !== 32'h1) begin num_fail++; $display("[TB] FAIL mcycle_low_wrap: got %h want %h", val, 32'h1); end
        write_csr(12'hB82, 32'h0);
        write_csr(12'hB02, 32'd10);
        cycle();
        xb_bubble = 1'b0;
        cycle();
        idle_inputs();
        read_csr(12'hB02, val);
        num_checks++;
        if (val !== 32'd11) begin num_fail++; $display("[TB] FAIL minstret_count: got %0d want %0d", val, 11); end
        write_csr(12'hB05, 32'h55);
        num_checks++;
        if (initiate_trap !== 1'b0) begin num_fail++; $display("[TB] FAIL hpm_write_legal: got %b want 0", initiate_trap); end
        read_csr(12'hB05, val);
        num_checks++;
        if (val !== 32'h0) begin num_fail++; $display("[TB] FAIL hpm_reads_zero: got %h want 0", val); end
    endtask

    task automatic test_suppression();
        write_csr(12'h340, 32'h1234);
        drive_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 12'h340, 32'h0, 5'd0);
        cycle();
        drive_op(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 12'h340, 32'hFFFF, 5'd0);
        cycle();
        idle_inputs();
        read_csr(12'h340, val);
        num_checks++;
        if (val !== 32'h1234) begin num_fail++; $display("[TB] FAIL suppressed_writes: got %h want %h", val, 32'h1234); end
        drive_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 12'h340, 32'h0, 5'd3);
        cycle();
        drive_op(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 12'h340, 32'h0, 5'd4);
        cycle();
        idle_inputs();
        read_csr(12'h340, val);
        num_checks++;
        if (val !== 32'h1233) begin num_fail++; $display("[TB] FAIL set_clear_imm: got %h want %h", val, 32'h1233); end
    endtask

    task automatic test_masks();
        write_csr(12'h304, 32'hFFFF_FFFF);
        read_csr(12'h304, val);
        num_checks++;
        if (val !== 32'h000F_0888) begin num_fail++; $display("[TB] FAIL mie_mask: got %h want %h", val, 32'h000F_0888); end
        write_csr(12'h344, 32'hFFFF_FFFF);
        num_checks++;
        if (initiate_trap !== 1'b0) begin num_fail++; $display("[TB] FAIL mip_write_legal: got %b want 0", initiate_trap); end
        read_csr(12'h344, val);
        num_checks++;
        if (val !== 32'h0) begin num_fail++; $display("[TB] FAIL mip_read_only: got %h want 0", val); end
        write_csr(12'h341, 32'h1003);
        read_csr(12'h341, val);
        num_checks++;
        if (val !== 32'h1000) begin num_fail++; $display("[TB] FAIL mepc_align: got %h want %h", val, 32'h1000); end
    endtask

    task automatic test_local_irq();
        write_csr(12'h305, 32'h101);
        write_csr(12'h304, 32'h000C_0000);
        drive_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 12'h300, 32'h0, 5'd8);
        cycle();
        idle_inputs();
        xb_bubble = 1'b0; xb_pc = 32'h700; irq_local = 4'b1100;
        cycle();
        num_checks++;
        if (initiate_trap !== 1'b0) begin num_fail++; $display("[TB] FAIL local_sync_delay: got %b want 0", initiate_trap); end
        cycle();
        num_checks++;
        if (initiate_trap !== 1'b1) begin num_fail++; $display("[TB] FAIL local_trap: got %b want 1", initiate_trap); end
        num_checks++;
        if (trap_target !== LOCAL_TARGET) begin num_fail++; $display("[TB] FAIL local_target: got %h want %h", trap_target, LOCAL_TARGET); end
        cycle();
        idle_inputs();
        read_csr(12'h342, val);
        num_checks++;
        if (val !== 32'h8000_0012) begin num_fail++; $display("[TB] FAIL local_mcause: got %h want %h", val, 32'h8000_0012); end
        read_csr(12'h305, val);
        num_checks++;
        if (val !== MTVEC_READ) begin num_fail++; $display("[TB] FAIL mtvec_mode: got %h want %h", val, MTVEC_READ); end
        irq_local = '0;
        cycle(); cycle(); cycle();
    endtask

    task automatic test_reset_mid_trap();
        read_csr(12'h301, val);
        drive_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 12'h7C0, 32'h1, 5'd1);
        cycle();
        idle_inputs();
        num_checks++;
        if (initiate_trap !== 1'b1) begin num_fail++; $display("[TB] FAIL pre_reset_trap: got %b want 1", initiate_trap); end
        reset = 1'b1;
        #1;
        num_checks++;
        if (initiate_trap !== 1'b0) begin num_fail++; $display("[TB] FAIL reset_kills_trap: got %b want 0", initiate_trap); end
        num_checks++;
        if (data_out !== 32'h0) begin num_fail++; $display("[TB] FAIL reset_clears_data: got %h want 0", data_out); end
        cycle();
        reset = 1'b0;
        cycle();
        read_csr(12'h305, val);
        num_checks++;
        if (val !== 32'h4) begin num_fail++; $display("[TB] FAIL reset_mtvec: got %h want %h", val, 32'h4); end
        read_csr(12'h304, val);
        num_checks++;
        if (val !== 32'h0) begin num_fail++; $display("[TB] FAIL reset_mie: got %h want 0", val); end
        read_csr(12'h342, val);
        num_checks++;
        if (val !== 32'h0) begin num_fail++; $display("[TB] FAIL reset_mcause: got %h want 0", val); end
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_irq();
        test_exc_priority();
        test_back_to_back();
        test_counters();
        test_suppression();
        test_masks();
        test_local_irq();
        test_reset_mid_trap();
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end
endmodule
